// File: rtl/bpu_pkg.sv
// Shared branch-prediction front-end types, widths and address helpers.
package bpu_pkg;

    localparam int unsigned MXLEN      = 32;
    localparam int unsigned GHR_W      = 10;
    localparam int unsigned FBLK_BYTES = 8;

    localparam logic [MXLEN-1:0] RESET_VEC_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StRun   = 2'd1,
        StStall = 2'd2
    } pc_state_e;

    // Slots are 32-bit, so any target is forced onto a word boundary.
    function automatic logic [MXLEN-1:0] word_align(input logic [MXLEN-1:0] addr);
        return {addr[MXLEN-1:2], 2'b00};
    endfunction

    function automatic logic [MXLEN-1:0] next_block(input logic [MXLEN-1:0] addr);
        return (addr & ~MXLEN'(FBLK_BYTES - 1)) + MXLEN'(FBLK_BYTES);
    endfunction

    function automatic logic [GHR_W-1:0] ghr_push(input logic [GHR_W-1:0] hist,
                                                  input logic             dir);
        return {hist[GHR_W-2:0], dir};
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Request/prediction/redirect bundle between pc_gen and its neighbours.
interface pc_gen_if;
    import bpu_pkg::*;

    logic             i_fetch_stall;
    logic             i_bru_redirect;
    logic [MXLEN-1:0] i_bru_target;
    logic [GHR_W-1:0] i_bru_ghr;
    logic             i_bru_taken;
    logic             i_pred_vld;
    logic             i_pred_br;
    logic             i_pred_taken;
    logic [MXLEN-1:0] i_pred_target;
    logic [MXLEN-1:0] o_pcGen_nPc;
    logic [MXLEN-1:0] o_pcGen_cPc;
    logic             o_pc_valid;
    logic             o_pc1_valid;
    logic             o_pc2_valid;
    logic [GHR_W-1:0] o_ghr;

    modport master (
        input  i_fetch_stall, i_bru_redirect, i_bru_target, i_bru_ghr, i_bru_taken,
        input  i_pred_vld, i_pred_br, i_pred_taken, i_pred_target,
        output o_pcGen_nPc, o_pcGen_cPc, o_pc_valid, o_pc1_valid, o_pc2_valid, o_ghr
    );

    modport slave (
        output i_fetch_stall, i_bru_redirect, i_bru_target, i_bru_ghr, i_bru_taken,
        output i_pred_vld, i_pred_br, i_pred_taken, i_pred_target,
        input  o_pcGen_nPc, o_pcGen_cPc, o_pc_valid, o_pc1_valid, o_pc2_valid, o_ghr
    );

endinterface

// File: rtl/pc_gen_ghr_ctrl.sv
// Speculative global history: restore from a backend snapshot or shift in a prediction.
module ghr_ctrl
    import bpu_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_restore,
    input  logic [GHR_W-1:0] i_restore_ghr,
    input  logic             i_restore_dir,
    input  logic             i_shift,
    input  logic             i_shift_dir,
    output logic [GHR_W-1:0] o_ghr
);

    logic [GHR_W-1:0] ghr_d;
    logic [GHR_W-1:0] ghr_q;

    // Restore takes precedence so a same-cycle prediction cannot pollute history.
    always_comb begin
        ghr_d = ghr_q;
        if (i_restore) begin
            ghr_d = ghr_push(i_restore_ghr, i_restore_dir);
        end else if (i_shift) begin
            ghr_d = ghr_push(ghr_q, i_shift_dir);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign o_ghr = ghr_q;

endmodule

// File: rtl/pc_gen.sv
// Next fetch-block PC selection, slot valids and speculative history ownership.
module pc_gen
    import bpu_pkg::*;
#(
    parameter logic [MXLEN-1:0] RESET_VEC = RESET_VEC_DEFAULT
) (
    input  logic  i_clk,
    input  logic  i_rst,
    pc_gen_if.master bus
);

    pc_state_e        state_d;
    pc_state_e        state_q;
    logic [MXLEN-1:0] cpc_d;
    logic [MXLEN-1:0] cpc_q;
    logic [MXLEN-1:0] npc;
    logic             pc_valid;
    logic             ghr_restore;
    logic             ghr_shift;

    always_comb begin
        state_d     = state_q;
        npc         = cpc_q;
        pc_valid    = 1'b0;
        ghr_restore = 1'b0;
        ghr_shift   = 1'b0;
        if (state_q == StBoot) begin
            npc     = RESET_VEC;
            state_d = StRun;
        end else begin
            pc_valid = 1'b1;
            if (bus.i_bru_redirect) begin
                npc         = word_align(bus.i_bru_target);
                state_d     = StRun;
                ghr_restore = 1'b1;
            end else if (bus.i_fetch_stall) begin
                npc     = cpc_q;
                state_d = StStall;
            end else begin
                state_d   = StRun;
                ghr_shift = bus.i_pred_vld & bus.i_pred_br;
                if (bus.i_pred_vld && bus.i_pred_taken) begin
                    npc = word_align(bus.i_pred_target);
                end else begin
                    npc = next_block(cpc_q);
                end
            end
        end
        cpc_d = npc;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StBoot;
            cpc_q   <= RESET_VEC;
        end else begin
            state_q <= state_d;
            cpc_q   <= cpc_d;
        end
    end

    ghr_ctrl u_ghr_ctrl (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_restore     (ghr_restore),
        .i_restore_ghr (bus.i_bru_ghr),
        .i_restore_dir (bus.i_bru_taken),
        .i_shift       (ghr_shift),
        .i_shift_dir   (bus.i_pred_taken),
        .o_ghr         (bus.o_ghr)
    );

    // A block entered at offset 4 only carries its upper slot.
    assign bus.o_pcGen_nPc = npc;
    assign bus.o_pcGen_cPc = cpc_q;
    assign bus.o_pc_valid  = pc_valid;
    assign bus.o_pc1_valid = pc_valid & ~npc[2];
    assign bus.o_pc2_valid = pc_valid;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with an arithmetic reference model checked every cycle.
module tb_pc_gen;

    localparam logic [31:0] RV = 32'h8000_0000;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    pc_gen_if bus ();

    pc_gen #(
        .RESET_VEC (RV)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state, in terms of fetch-block addresses and a history integer.
    bit          m_known = 1'b0;
    bit          m_boot  = 1'b1;
    logic [31:0] m_cpc   = '0;
    int unsigned m_ghr   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_npc();
        logic [31:0] t;
        if (m_boot) return RV;
        if (bus.i_bru_redirect) begin
            t = bus.i_bru_target;
            return t - (t % 4);
        end
        if (bus.i_fetch_stall) return m_cpc;
        if (bus.i_pred_vld && bus.i_pred_taken) begin
            t = bus.i_pred_target;
            return t - (t % 4);
        end
        return 32'(m_cpc - (m_cpc % 8) + 32'd8);
    endfunction

    always @(posedge i_clk) begin
        if (i_rst) begin
            m_known <= 1'b1;
            m_boot  <= 1'b1;
            m_cpc   <= RV;
            m_ghr   <= 0;
        end else if (m_known) begin
            m_boot <= 1'b0;
            m_cpc  <= exp_npc();
            if (!m_boot) begin
                if (bus.i_bru_redirect)
                    m_ghr <= (32'(bus.i_bru_ghr) * 2 + 32'(bus.i_bru_taken)) % 1024;
                else if (!bus.i_fetch_stall && bus.i_pred_vld && bus.i_pred_br)
                    m_ghr <= (m_ghr * 2 + 32'(bus.i_pred_taken)) % 1024;
            end
        end
    end

    always @(negedge i_clk) begin
        logic [31:0] e;
        if (m_known) begin
            e = exp_npc();
            chk("npc", bus.o_pcGen_nPc, e);
            chk("cpc", bus.o_pcGen_cPc, m_cpc);
            chk("ghr", 32'(bus.o_ghr), m_ghr);
            chk("pc_valid", 32'(bus.o_pc_valid), 32'(!m_boot));
            chk("pc1_valid", 32'(bus.o_pc1_valid), 32'(!m_boot && (e % 8) == 0));
            chk("pc2_valid", 32'(bus.o_pc2_valid), 32'(!m_boot));
        end
    end

    task automatic cyc(input logic rst, input logic stall, input logic redir,
                       input logic [31:0] btgt, input logic [9:0] bghr, input logic btkn,
                       input logic pvld, input logic pbr, input logic ptkn,
                       input logic [31:0] ptgt);
        @(posedge i_clk);
        #1;
        i_rst              = rst;
        bus.i_fetch_stall  = stall;
        bus.i_bru_redirect = redir;
        bus.i_bru_target   = btgt;
        bus.i_bru_ghr      = bghr;
        bus.i_bru_taken    = btkn;
        bus.i_pred_vld     = pvld;
        bus.i_pred_br      = pbr;
        bus.i_pred_taken   = ptkn;
        bus.i_pred_target  = ptgt;
        @(negedge i_clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        bus.i_fetch_stall  = 1'b0;
        bus.i_bru_redirect = 1'b0;
        bus.i_bru_target   = '0;
        bus.i_bru_ghr      = '0;
        bus.i_bru_taken    = 1'b0;
        bus.i_pred_vld     = 1'b0;
        bus.i_pred_br      = 1'b0;
        bus.i_pred_taken   = 1'b0;
        bus.i_pred_target  = '0;

        cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("boot_npc", bus.o_pcGen_nPc, 32'h8000_0000);
        chk("boot_valid", 32'(bus.o_pc_valid), 32'd0);
        idle();
        idle();
        chk("run0_cpc", bus.o_pcGen_cPc, 32'h8000_0000);
        chk("run0_npc", bus.o_pcGen_nPc, 32'h8000_0008);
        chk("run0_pc1", 32'(bus.o_pc1_valid), 32'd1);
        idle();
        chk("run1_npc", bus.o_pcGen_nPc, 32'h8000_0010);

        // Taken prediction into offset 4 of a block.
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0104);
        chk("pred_cpc", bus.o_pcGen_cPc, 32'h8000_0010);
        chk("pred_npc", bus.o_pcGen_nPc, 32'h8000_0104);
        chk("pred_pc1", 32'(bus.o_pc1_valid), 32'd0);
        chk("pred_pc2", 32'(bus.o_pc2_valid), 32'd1);
        idle();
        chk("pred_ghr", 32'(bus.o_ghr), 32'h1);
        chk("seq_off4", bus.o_pcGen_nPc, 32'h8000_0108);

        // Taken non-branch jump: no history effect.
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_0020);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0040);
            chk("stall_npc", bus.o_pcGen_nPc, 32'h8000_0020);
            chk("stall_ghr", 32'(bus.o_ghr), 32'h1);
        end
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0040);
        chk("release_npc", bus.o_pcGen_nPc, 32'h8000_0040);
        cyc(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("release_ghr", 32'(bus.o_ghr), 32'h3);

        // Redirect while stalled beats both stall and a taken prediction.
        cyc(1'b0, 1'b1, 1'b1, 32'h8000_0203, 10'h155, 1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0300);
        chk("redir_npc", bus.o_pcGen_nPc, 32'h8000_0200);
        chk("redir_pc1", 32'(bus.o_pc1_valid), 32'd1);
        idle();
        chk("redir_ghr", 32'(bus.o_ghr), 32'h2AA);
        chk("redir_seq", bus.o_pcGen_nPc, 32'h8000_0208);

        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        idle();
        chk("wrap_cpc", bus.o_pcGen_cPc, 32'hFFFF_FFF8);
        chk("wrap_npc", bus.o_pcGen_nPc, 32'h0000_0000);

        // Reset mid-stall; redirect and prediction ignored in the boot cycle.
        cyc(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_1234, 10'h0AA, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_4444);
        chk("rst_stall_cpc", bus.o_pcGen_cPc, 32'h8000_0000);
        chk("rst_stall_valid", 32'(bus.o_pc_valid), 32'd0);
        chk("rst_stall_npc", bus.o_pcGen_nPc, 32'h8000_0000);
        chk("rst_stall_ghr", 32'(bus.o_ghr), 32'h0);
        idle();
        chk("boot_ignores_npc", bus.o_pcGen_nPc, 32'h8000_0008);
        chk("boot_ignores_ghr", 32'(bus.o_ghr), 32'h0);

        // Reset asserted together with a redirect.
        cyc(1'b1, 1'b0, 1'b1, 32'h1000_0004, 10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("rst_redir_cpc", bus.o_pcGen_cPc, 32'h8000_0000);
        chk("rst_redir_valid", 32'(bus.o_pc_valid), 32'd0);
        idle();

        // Mixed directed traffic, checked by the model.
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, (i % 4) == 2, (i % 3) == 0, 32'h4000_0000 + 32'(i * 12),
                10'(i * 37), i[0], 1'b1, (i % 2) == 1, (i % 5) < 2,
                32'h2000_0000 + 32'(i * 20));
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
